// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handoff
// and the controller's redirect inputs.
interface fetch_unit_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemValid;
    logic [31:0] IMemData;

    logic        InstrValid;
    logic [31:0] Instruction;
    logic [31:0] PCPlus4;
    logic        DecodeReady;

    logic        Branch;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [25:0] JumpIndex;
    logic        JumpReg;
    logic [31:0] RegTarget;

    modport master (
        output IMemReq, IMemAddr, InstrValid, Instruction, PCPlus4,
        input  IMemValid, IMemData, DecodeReady,
        input  Branch, BranchTarget, Jump, JumpIndex, JumpReg, RegTarget
    );

    modport slave (
        input  IMemReq, IMemAddr, InstrValid, Instruction, PCPlus4,
        output IMemValid, IMemData, DecodeReady,
        output Branch, BranchTarget, Jump, JumpIndex, JumpReg, RegTarget
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, a 2-entry
// instruction queue feeding decode, and J/JR/branch redirect with flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          Clk,
    input logic          Reset,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,  // no request outstanding
        WAIT,  // request outstanding, response will be queued
        DROP   // request outstanding, response belongs to a flushed path
    } state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    state_e           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    entry_t [1:0]     queue_q, queue_d;
    logic [1:0]       count_q, count_d;

    logic             accept;
    logic             redirect;
    logic [31:0]      target_raw;
    logic [31:0]      target;
    logic [1:0]       count_popped;
    logic             issue;
    logic             push;

    // Handshake decode and redirect target selection.
    always_comb begin
        accept   = (count_q != 2'd0) && bus.DecodeReady;
        redirect = accept && (bus.Branch || bus.Jump || bus.JumpReg);

        if (bus.JumpReg) begin
            target_raw = bus.RegTarget;
        end else if (bus.Jump) begin
            target_raw = {queue_q[0].pc4[31:28], bus.JumpIndex, 2'b00};
        end else begin
            target_raw = bus.BranchTarget;
        end
        target = target_raw & ~32'h0000_0003;

        count_popped = count_q - {1'b0, accept};
        // A redirect cycle never issues: the next fetch must come from the target.
        issue = Reset && (state_q == IDLE) && !redirect && (count_popped != 2'd2);
        push  = (state_q == WAIT) && bus.IMemValid && !redirect;
    end

    // Next-state logic for FSM, fetch PC and queue.
    always_comb begin
        // NOTE: every _d starts from its _q so no path can infer a latch.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        queue_d    = queue_q;
        count_d    = count_q;

        unique case (state_q)
            IDLE: if (issue) state_d = WAIT;
            WAIT: begin
                if (bus.IMemValid)  state_d = IDLE;
                else if (redirect)  state_d = DROP;
            end
            DROP: if (bus.IMemValid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            fetch_pc_d = target;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (issue) begin
            req_pc_d = fetch_pc_q;
        end

        if (redirect) begin
            count_d = 2'd0;
        end else begin
            if (accept) begin
                queue_d[0] = queue_q[1];
            end
            // A push can only land while at most one entry survives the pop.
            if (push) begin
                if (count_popped == 2'd0) begin
                    queue_d[0] = '{instr: bus.IMemData, pc4: req_pc_q + 32'd4};
                end else begin
                    queue_d[1] = '{instr: bus.IMemData, pc4: req_pc_q + 32'd4};
                end
            end
            count_d = count_popped + {1'b0, push};
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            count_q    <= 2'd0;
            // NOTE: queue storage is reset too, so Instruction/PCPlus4 read 0 in reset.
            queue_q    <= '0;
        end else begin
            // NOTE: non-blocking so every flop updates from the same pre-edge values.
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            queue_q    <= queue_d;
        end
    end

    assign bus.IMemReq     = issue;
    assign bus.IMemAddr    = fetch_pc_q;
    assign bus.InstrValid  = (count_q != 2'd0);
    assign bus.Instruction = queue_q[0].instr;
    assign bus.PCPlus4     = queue_q[0].pc4;

endmodule
